// File: rtl/dec_counter_pkg.sv
// Shared types for the down-counter: FSM state encoding and decrement-path structure selectors.
// Latency: n/a (declarations only).  Backpressure: n/a.
package dec_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SPEED_SERIAL     = 0;
    localparam int SPEED_BRENT_KUNG = 1;
    localparam int SPEED_SKLANSKY   = 2;

endpackage

// File: rtl/dec_core.sv
// Combinational A-1 via prefix-AND of the inverted operand; SPEED picks serial, Brent-Kung or Sklansky.
// Latency: 0 cycles.  Backpressure: none; the result saturates at zero instead of wrapping.
module dec_core
    import dec_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SPEED = SPEED_SERIAL
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_z
);

    localparam int LVLS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_borrow;
    logic             w_zero;

    assign w_inv = ~i_a;

    // w_pre[i] = 1 when bits i..0 of the operand are all zero, i.e. a borrow reaches bit i+1
    generate
        if (SPEED == SPEED_SKLANSKY) begin : g_sklansky
            always_comb begin
                logic [WIDTH-1:0] p;
                p = w_inv;
                for (int k = 0; k < LVLS; k++) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i >> k) & 1) == 1) begin
                            p[i] = p[i] & p[((i >> k) << k) - 1];
                        end
                    end
                end
                w_pre = p;
            end
        end else if (SPEED == SPEED_BRENT_KUNG) begin : g_brent_kung
            always_comb begin
                logic [WIDTH-1:0] p;
                p = w_inv;
                for (int k = 0; k < LVLS; k++) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i + 1) % (1 << (k + 1))) == 0) begin
                            p[i] = p[i] & p[i - (1 << k)];
                        end
                    end
                end
                for (int k = LVLS - 2; k >= 0; k--) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if ((i >= (1 << (k + 1))) && (((i + 1) % (1 << (k + 1))) == (1 << k))) begin
                            p[i] = p[i] & p[i - (1 << k)];
                        end
                    end
                end
                w_pre = p;
            end
        end else begin : g_serial
            always_comb begin
                logic [WIDTH-1:0] p;
                p    = w_inv;
                for (int i = 1; i < WIDTH; i++) begin
                    p[i] = p[i - 1] & w_inv[i];
                end
                w_pre = p;
            end
        end
    endgenerate

    assign w_borrow = {w_pre[WIDTH-2:0], 1'b1};
    assign w_zero   = w_pre[WIDTH-1];
    assign o_z      = w_zero ? '0 : (i_a ^ w_borrow);

endmodule

// File: rtl/dec_counter.sv
// Loadable saturating down-counter with IDLE/RUN/DONE FSM and terminal-count pulse; DEC_COUNTER_RELOAD_EN adds auto-reload.
// Latency: 1 cycle per load or decrement; cnt_o, state and tc_o are registered.  Backpressure: load_ready_o is low in RUN.
module dec_counter
    import dec_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SPEED = SPEED_SERIAL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             abort_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] reload_val_i,
    input  logic             reload_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tc_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_dec;
    logic             r_tc;
    logic             w_tc_req;
    logic             w_load_acc;
    logic             w_term;

    dec_core #(
        .WIDTH (WIDTH),
        .SPEED (SPEED)
    ) u_dec_core (
        .i_a (r_cnt),
        .o_z (w_dec)
    );

    assign load_ready_o = (r_state != RUN);
    assign w_load_acc   = load_valid_i && load_ready_o;
    assign w_term       = (r_cnt == WIDTH'(1));

`ifndef DEC_COUNTER_RELOAD_EN
    logic w_unused;
    assign w_unused = ^{reload_i, reload_val_i};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc_req    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_load_acc) begin
                    w_cnt_nxt = load_val_i;
                    if (load_val_i == '0) begin
                        w_state_nxt = DONE;
                        w_tc_req    = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if ((r_state == DONE) && clear_i) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (en_i) begin
                    if (w_term) begin
                        w_tc_req = 1'b1;
`ifdef DEC_COUNTER_RELOAD_EN
                        if (reload_i && (reload_val_i != '0)) begin
                            w_cnt_nxt = reload_val_i;
                        end else begin
                            w_cnt_nxt   = w_dec;
                            w_state_nxt = DONE;
                        end
`else
                        w_cnt_nxt   = w_dec;
                        w_state_nxt = DONE;
`endif
                    end else begin
                        w_cnt_nxt = w_dec;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A pulse requested right after another one is dropped so tc_o never stretches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_req & ~r_tc;
        end
    end

    assign cnt_o  = r_cnt;
    assign tc_o   = r_tc;
    assign busy_o = (r_state == RUN);
    assign done_o = (r_state == DONE);

endmodule

// File: tb/tb_dec_counter.sv
// Self-checking bench for dec_counter: scenario tasks with a queue scoreboard, plus a SPEED x WIDTH sweep.
module tb_dec_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic       busy;
        logic       done;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic       ready;
    logic [7:0] load_val;
    logic       en;
    logic       abort;
    logic       clear;
    logic [7:0] reload_val;
    logic       reload;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tc;

    int n_checks = 0;
    int n_errors = 0;

    obs_t exp_q[$];
    logic [64:0] sw_q[$];

    always #5 clk = ~clk;

    dec_counter #(.WIDTH(8), .SPEED(0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_valid_i (load_valid),
        .load_ready_o (ready),
        .load_val_i   (load_val),
        .en_i         (en),
        .abort_i      (abort),
        .clear_i      (clear),
        .reload_val_i (reload_val),
        .reload_i     (reload),
        .cnt_o        (cnt),
        .busy_o       (busy),
        .done_o       (done),
        .tc_o         (tc)
    );

    // Sweep instances: SPEED 0..2 crossed with WIDTH 2,7,8,13,32
    logic        sw_lv;
    logic        sw_en;
    logic [63:0] sw_load_val;
    logic [63:0] sw_cnt  [15];
    logic        sw_done [15];
    logic        sw_busy [15];
    logic        sw_tc   [15];
    logic        sw_rdy  [15];

    function automatic int wid(input int k);
        case (k)
            0: return 2;
            1: return 7;
            2: return 8;
            3: return 13;
            default: return 32;
        endcase
    endfunction

    for (genvar s = 0; s < 3; s++) begin : g_spd
        for (genvar w = 0; w < 5; w++) begin : g_wid
            localparam int W   = (w == 0) ? 2 : (w == 1) ? 7 : (w == 2) ? 8 : (w == 3) ? 13 : 32;
            localparam int IDX = s * 5 + w;
            logic [W-1:0] c;
            dec_counter #(.WIDTH(W), .SPEED(s)) u_sw (
                .clk_i        (clk),
                .rst_ni       (rst_n),
                .load_valid_i (sw_lv),
                .load_ready_o (sw_rdy[IDX]),
                .load_val_i   (sw_load_val[W-1:0]),
                .en_i         (sw_en),
                .abort_i      (1'b0),
                .clear_i      (1'b0),
                .reload_val_i ({W{1'b0}}),
                .reload_i     (1'b0),
                .cnt_o        (c),
                .busy_o       (sw_busy[IDX]),
                .done_o       (sw_done[IDX]),
                .tc_o         (sw_tc[IDX])
            );
            assign sw_cnt[IDX] = 64'(c);
        end
    end

    function automatic obs_t mk(input logic [7:0] c, input logic t, input logic b,
                                input logic d, input logic r);
        return {c, t, b, d, r};
    endfunction

    function automatic obs_t cur();
        return {cnt, tc, busy, done, ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_val   = 8'h00;
        en         = 1'b0;
        abort      = 1'b0;
        clear      = 1'b0;
        reload     = 1'b0;
        reload_val = 8'h00;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t want;
        idle_inputs();
        sw_lv       = 1'b0;
        sw_en       = 1'b0;
        sw_load_val = 64'd0;
        rst_n       = 1'b0;
        #3;
        got = cur();
        n_checks++;
        if (got !== mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL reset_async: cnt/tc/busy/done/rdy got %h want %h", got, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        en = 1'b1;
        tick();
        want = exp_q.pop_front();
        got  = cur();
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL reset_release: got %h want %h", got, want);
        end
        en = 1'b0;
    endtask

    task automatic test_countdown();
        obs_t got;
        obs_t want;
        for (int c = 0; c < 10; c++) begin
            load_valid = (c == 0);
            load_val   = 8'd5;
            en         = (c != 9);
            clear      = (c == 9);
            if (c == 0)      exp_q.push_back(mk(8'd5, 1'b0, 1'b1, 1'b0, 1'b0));
            else if (c < 5)  exp_q.push_back(mk(8'(5 - c), 1'b0, 1'b1, 1'b0, 1'b0));
            else if (c == 5) exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b1, 1'b1));
            else if (c < 9)  exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
            else             exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            tick();
            want = exp_q.pop_front();
            got  = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL countdown[%0d]: got %h want %h", c, got, want);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load_zero();
        obs_t got;
        obs_t want;
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            case (c)
                0: begin load_valid = 1'b1; load_val = 8'd0;
                         exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b1, 1'b1)); end
                1: exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
                2: begin load_valid = 1'b1; load_val = 8'd3; clear = 1'b1;
                         exp_q.push_back(mk(8'd3, 1'b0, 1'b1, 1'b0, 1'b0)); end
                3: begin load_valid = 1'b1; load_val = 8'd9;
                         exp_q.push_back(mk(8'd3, 1'b0, 1'b1, 1'b0, 1'b0)); end
                4: begin abort = 1'b1;
                         exp_q.push_back(mk(8'd3, 1'b0, 1'b0, 1'b0, 1'b1)); end
                default: begin abort = 1'b1; en = 1'b1; clear = 1'b1;
                         exp_q.push_back(mk(8'd3, 1'b0, 1'b0, 1'b0, 1'b1)); end
            endcase
            tick();
            want = exp_q.pop_front();
            got  = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL load_zero[%0d]: got %h want %h", c, got, want);
            end
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        obs_t got;
        obs_t want;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            en = (c != 8);
            if (c == 0) begin
                load_valid = 1'b1; load_val = 8'h80;
                exp_q.push_back(mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
            end else if (c < 4) begin
                exp_q.push_back(mk(8'(8'h80 - c), 1'b0, 1'b1, 1'b0, 1'b0));
            end else if (c == 4) begin
                abort = 1'b1;
                exp_q.push_back(mk(8'h7D, 1'b0, 1'b0, 1'b0, 1'b1));
            end else if (c == 5) begin
                exp_q.push_back(mk(8'h7D, 1'b0, 1'b0, 1'b0, 1'b1));
            end else if (c == 6) begin
                load_valid = 1'b1; load_val = 8'd1;
                exp_q.push_back(mk(8'd1, 1'b0, 1'b1, 1'b0, 1'b0));
            end else begin
                abort = (c == 7);
                exp_q.push_back(mk(8'd1, 1'b0, 1'b0, 1'b0, 1'b1));
            end
            tick();
            want = exp_q.pop_front();
            got  = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL abort[%0d]: got %h want %h", c, got, want);
            end
        end
        idle_inputs();
    endtask

`ifdef DEC_COUNTER_RELOAD_EN
    task automatic test_reload();
        obs_t got;
        obs_t want;
        logic [7:0] ec [10];
        logic       et [10];
        ec = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 10; c++) begin
            load_valid = (c == 0);
            load_val   = 8'd2;
            en         = (c != 9);
            reload     = (c < 9);
            reload_val = (c >= 7) ? 8'd0 : 8'd3;
            clear      = (c == 9);
            exp_q.push_back(mk(ec[c], et[c], (c < 8), (c == 8), (c >= 8)));
            tick();
            want = exp_q.pop_front();
            got  = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reload[%0d]: got %h want %h", c, got, want);
            end
        end
        idle_inputs();
    endtask
`else
    task automatic test_no_reload();
        obs_t got;
        obs_t want;
        for (int c = 0; c < 3; c++) begin
            reload     = 1'b1;
            reload_val = 8'd3;
            load_valid = (c == 0);
            load_val   = 8'd1;
            en         = (c == 1);
            clear      = (c == 2);
            if (c == 0)      exp_q.push_back(mk(8'd1, 1'b0, 1'b1, 1'b0, 1'b0));
            else if (c == 1) exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 1'b1, 1'b1));
            else             exp_q.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            tick();
            want = exp_q.pop_front();
            got  = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL no_reload[%0d]: got %h want %h", c, got, want);
            end
        end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        obs_t got;
        obs_t want;
        load_valid = 1'b1; load_val = 8'h41;
        exp_q.push_back(mk(8'h41, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        load_valid = 1'b0; en = 1'b1;
        exp_q.push_back(mk(8'h40, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        for (int k = 0; k < 2; k++) begin
            want = exp_q.pop_front();
            if (k == 0) want = mk(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
            got = cur();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_mid_count[%0d]: got %h want %h", k, got, want);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = cur();
        n_checks++;
        if (got !== mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %h want %h", got, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        want = exp_q.pop_front();
        got  = cur();
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL reset_mid_release: got %h want %h", got, want);
        end
        idle_inputs();
    endtask

    task automatic test_speed_sweep();
        logic [63:0] m_cnt [15];
        bit          m_run [15];
        bit          m_done[15];
        logic [63:0] mask;
        logic [64:0] want;
        for (int i = 0; i < 15; i++) begin
            m_cnt[i] = 64'd0; m_run[i] = 1'b0; m_done[i] = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 30; c++) begin
                sw_lv       = (c == 0) || ($urandom_range(0, 5) == 0);
                sw_load_val = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 4))
                                                          : {$urandom, $urandom};
                sw_en       = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 15; i++) begin
                    mask = (64'd1 << wid(i % 5)) - 64'd1;
                    if (sw_lv && !m_run[i]) begin
                        m_cnt[i]  = sw_load_val & mask;
                        m_run[i]  = (m_cnt[i] != 64'd0);
                        m_done[i] = (m_cnt[i] == 64'd0);
                    end else if (m_run[i] && sw_en) begin
                        if (m_cnt[i] == 64'd1) begin
                            m_run[i]  = 1'b0;
                            m_done[i] = 1'b1;
                        end
                        m_cnt[i] = m_cnt[i] - 64'd1;
                    end
                    sw_q.push_back({m_done[i], m_cnt[i]});
                end
                tick();
                for (int i = 0; i < 15; i++) begin
                    want = sw_q.pop_front();
                    n_checks++;
                    if ({sw_done[i], sw_cnt[i]} !== want) begin
                        n_errors++;
                        $display("FAIL sweep speed=%0d width=%0d cyc=%0d: done/cnt got %b/%h want %b/%h",
                                 i / 5, wid(i % 5), r * 30 + c, sw_done[i], sw_cnt[i], want[64], want[63:0]);
                    end
                end
            end
        end
        sw_lv = 1'b0;
        sw_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_speed_sweep();
        test_countdown();
        test_load_zero();
        test_abort();
`ifdef DEC_COUNTER_RELOAD_EN
        test_reload();
`else
        test_no_reload();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
